// File: rtl/hazard_controller.sv
// hazard_controller
//   Pipeline sequencing controller for the 5-stage MIPS core. Produces stall
//   and flush controls for PC, IF/ID and ID/EX for the hazards forwarding
//   cannot resolve: load-use, taken branches/jumps and MDU occupancy.
//
//   Build option: define HAZARD_STATS_EN to build the saturating 16-bit
//   StallCount / FlushCount performance counters. Without it both ports
//   read 0 and no counter logic exists.
//
// Ports
//   clk, rst_n          core clock, asynchronous active-low reset
//   IF_ID_Rs/Rt/UsesRt  source operands of the instruction in ID
//   ID_MduUse, ID_Jump  ID instruction touches HI/LO or MDU, ID jump
//   ID_EX_MemRead/Rt    EX instruction is a load and its destination
//   ID_EX_MduStart/IsDiv EX instruction starts the MDU, div vs mult
//   EX_BranchTaken      branch resolved taken in EX
//   PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush  pipeline controls
//   MduBusy, MduDone    registered MDU occupancy / last-busy-cycle pulse
//   StallCount, FlushCount  performance counters
//
// MDU occupancy FSM
//   state | meaning
//   IDLE  | MDU free, cnt holds 0
//   BUSY  | MDU occupied, cnt = busy cycles remaining after this one
module hazard_controller #(
    parameter int MUL_LATENCY = 4,
    parameter int DIV_LATENCY = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  IF_ID_Rs,
    input  logic [4:0]  IF_ID_Rt,
    input  logic        IF_ID_UsesRt,
    input  logic        ID_MduUse,
    input  logic        ID_Jump,
    input  logic        ID_EX_MemRead,
    input  logic [4:0]  ID_EX_Rt,
    input  logic        ID_EX_MduStart,
    input  logic        ID_EX_MduIsDiv,
    input  logic        EX_BranchTaken,
    output logic        PC_Write,
    output logic        IF_ID_Write,
    output logic        IF_ID_Flush,
    output logic        ID_EX_Flush,
    output logic        MduBusy,
    output logic        MduDone,
    output logic [15:0] StallCount,
    output logic [15:0] FlushCount
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic [5:0] MUL_LOAD = 6'(MUL_LATENCY - 1);
    localparam logic [5:0] DIV_LOAD = 6'(DIV_LATENCY - 1);

    state_t     state, state_nxt;
    logic [5:0] cnt, cnt_nxt;
    logic       done_q, done_nxt;

    logic loaduse;
    logic mdustall;
    logic stall;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= 6'd0;
            done_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            done_q <= done_nxt;
        end
    end

    // Next-state logic. A start while BUSY simply restarts the count with
    // the new latency. done is precomputed so MduDone is a flop output that
    // is high exactly during the cycle where cnt reads 0.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        done_nxt  = 1'b0;
        if (ID_EX_MduStart) begin
            state_nxt = BUSY;
            cnt_nxt   = ID_EX_MduIsDiv ? DIV_LOAD : MUL_LOAD;
            done_nxt  = (cnt_nxt == 6'd0);
        end else if (state == BUSY) begin
            if (cnt != 6'd0) begin
                cnt_nxt  = cnt - 6'd1;
                done_nxt = (cnt == 6'd1);
            end else begin
                state_nxt = IDLE;
            end
        end
    end

    assign MduBusy = (state == BUSY);
    assign MduDone = done_q;

    // Output logic
    always_comb begin
        loaduse = ID_EX_MemRead && (ID_EX_Rt != 5'd0) &&
                  ((ID_EX_Rt == IF_ID_Rs) || (IF_ID_UsesRt && (ID_EX_Rt == IF_ID_Rt)));
        // HI/LO is readable during the MduDone cycle, hence the ~MduDone.
        mdustall = ID_MduUse && ((MduBusy && !MduDone) || ID_EX_MduStart);
        stall    = loaduse || mdustall;

        PC_Write    = 1'b1;
        IF_ID_Write = 1'b1;
        IF_ID_Flush = 1'b0;
        ID_EX_Flush = 1'b0;
        if (EX_BranchTaken) begin
            // ID holds a wrong-path instruction, so any stall it raised is moot.
            IF_ID_Flush = 1'b1;
            ID_EX_Flush = 1'b1;
        end else if (stall) begin
            // A pending jump is re-evaluated once the stall clears.
            PC_Write    = 1'b0;
            IF_ID_Write = 1'b0;
            ID_EX_Flush = 1'b1;
        end else if (ID_Jump) begin
            IF_ID_Flush = 1'b1;
        end
    end

`ifdef HAZARD_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            StallCount <= 16'd0;
            FlushCount <= 16'd0;
        end else begin
            if (stall && !EX_BranchTaken && (StallCount != 16'hFFFF))
                StallCount <= StallCount + 16'd1;
            if (IF_ID_Flush && (FlushCount != 16'hFFFF))
                FlushCount <= FlushCount + 16'd1;
        end
    end
`else
    assign StallCount = 16'd0;
    assign FlushCount = 16'd0;
`endif

endmodule

// File: tb/tb_hazard_controller.sv
`timescale 1ns/1ps
module tb_hazard_controller;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [4:0]  rs = 5'd0, rt = 5'd0, ex_rt = 5'd0;
    logic        uses_rt = 1'b0, mdu_use = 1'b0, jump = 1'b0, memrd = 1'b0;
    logic        start = 1'b0, is_div = 1'b0, br = 1'b0;
    logic        pc_write, if_id_write, if_id_flush, id_ex_flush, mdu_busy, mdu_done;
    logic [15:0] stall_count, flush_count;

    hazard_controller #(.MUL_LATENCY(4), .DIV_LATENCY(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .IF_ID_Rs(rs), .IF_ID_Rt(rt), .IF_ID_UsesRt(uses_rt),
        .ID_MduUse(mdu_use), .ID_Jump(jump),
        .ID_EX_MemRead(memrd), .ID_EX_Rt(ex_rt),
        .ID_EX_MduStart(start), .ID_EX_MduIsDiv(is_div),
        .EX_BranchTaken(br),
        .PC_Write(pc_write), .IF_ID_Write(if_id_write),
        .IF_ID_Flush(if_id_flush), .ID_EX_Flush(id_ex_flush),
        .MduBusy(mdu_busy), .MduDone(mdu_done),
        .StallCount(stall_count), .FlushCount(flush_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    typedef struct {
        string      tag;
        logic [5:0] exp;
    } sb_t;
    sb_t sb[$];

    // Reference model state
    int          m_rem = 0;       // busy cycles remaining including current
    int          m_stall_cnt = 0;
    int          m_flush_cnt = 0;
    logic [5:0]  last_obs;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic model_stall();
        logic lu, ms, busy, done;
        busy = (m_rem != 0);
        done = (m_rem == 1);
        lu = memrd && (ex_rt != 5'd0) && ((ex_rt == rs) || (uses_rt && (ex_rt == rt)));
        ms = mdu_use && ((busy && !done) || start);
        return lu || ms;
    endfunction

    // Expected {PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, MduBusy, MduDone}
    function automatic logic [5:0] model_out();
        logic [3:0] ctl;
        logic st;
        st = model_stall();
        if (br)          ctl = 4'b1111;
        else if (st)     ctl = 4'b0001;
        else if (jump)   ctl = 4'b1110;
        else             ctl = 4'b1100;
        return {ctl, (m_rem != 0), (m_rem == 1)};
    endfunction

    task automatic set_in(input logic [4:0] i_rs, input logic [4:0] i_rt, input logic i_uses,
                          input logic i_mdu, input logic i_jmp, input logic i_mrd,
                          input logic [4:0] i_exrt, input logic i_start, input logic i_div,
                          input logic i_br);
        rs = i_rs; rt = i_rt; uses_rt = i_uses; mdu_use = i_mdu; jump = i_jmp;
        memrd = i_mrd; ex_rt = i_exrt; start = i_start; is_div = i_div; br = i_br;
    endtask

    // One clock of stimulus: push expectation, compare mid-cycle, advance model.
    task automatic cycle(input string tag);
        sb_t e;
        logic [5:0] exp_v;
        logic st;
        exp_v = model_out();
        st = model_stall();
        sb.push_back('{tag, exp_v});
        @(negedge clk);
        e = sb.pop_front();
        last_obs = {pc_write, if_id_write, if_id_flush, id_ex_flush, mdu_busy, mdu_done};
        check(e.tag, {26'd0, last_obs}, {26'd0, e.exp});
        @(posedge clk);
        if (st && !br && m_stall_cnt < 16'hFFFF) m_stall_cnt++;
        if (exp_v[3] && m_flush_cnt < 16'hFFFF) m_flush_cnt++;
        if (start)           m_rem = is_div ? 32 : 4;
        else if (m_rem != 0) m_rem--;
        #1;
    endtask

    task automatic check_counts(input string tag);
`ifdef HAZARD_STATS_EN
        check({tag, "_stallcnt"}, {16'd0, stall_count}, m_stall_cnt);
        check({tag, "_flushcnt"}, {16'd0, flush_count}, m_flush_cnt);
`else
        check({tag, "_stallcnt"}, {16'd0, stall_count}, 32'd0);
        check({tag, "_flushcnt"}, {16'd0, flush_count}, 32'd0);
`endif
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        m_rem = 0; m_stall_cnt = 0; m_flush_cnt = 0;
        #3;
        check({tag, "_outs"},
              {26'd0, pc_write, if_id_write, if_id_flush, id_ex_flush, mdu_busy, mdu_done},
              {26'd0, 6'b110000});
        check_counts(tag);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int stalls;
        int dones;

        do_reset("rst0");

        // Load-use on Rs: lw $8 in EX, add $9,$8,$1 in ID
        set_in(8, 1, 1, 0, 0, 1, 8, 0, 0, 0); cycle("lu_rs");
        set_in(8, 1, 1, 0, 0, 0, 0, 0, 0, 0); cycle("lu_bubble");
        set_in(0, 1, 1, 0, 0, 1, 0, 0, 0, 0); cycle("lu_r0");
        // Load-use on Rt, then Rt not used
        set_in(3, 5, 1, 0, 0, 1, 5, 0, 0, 0); cycle("lu_rt");
        set_in(3, 5, 0, 0, 0, 1, 5, 0, 0, 0); cycle("lu_rt_unused");
        set_in(3, 7, 1, 0, 0, 1, 5, 0, 0, 0); cycle("lu_nomatch");
        // Jumps
        set_in(0, 0, 0, 0, 1, 0, 0, 0, 0, 0); cycle("jump");
        set_in(8, 0, 0, 0, 1, 1, 8, 0, 0, 0); cycle("jump_stalled");
        set_in(8, 0, 0, 0, 1, 0, 0, 0, 0, 0); cycle("jump_retry");
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 1); cycle("branch");
        check_counts("mix");

        // Branch over a load-use stall from a clean reset
        do_reset("rst1");
        set_in(8, 1, 1, 0, 0, 1, 8, 0, 0, 1); cycle("br_over_lu");
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
`ifdef HAZARD_STATS_EN
        check("br_stallcnt", {16'd0, stall_count}, 32'd0);
        check("br_flushcnt", {16'd0, flush_count}, 32'd1);
`else
        check("br_stallcnt", {16'd0, stall_count}, 32'd0);
        check("br_flushcnt", {16'd0, flush_count}, 32'd0);
`endif

        // Divide with mflo held in ID
        set_in(0, 0, 0, 0, 0, 0, 0, 1, 1, 0); cycle("div_start");
        set_in(0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        stalls = 0; dones = 0;
        for (int i = 0; i < 32; i++) begin
            cycle("div_wait");
            if (!last_obs[5]) stalls++;
            if (last_obs[0])  dones++;
        end
        check("div_stall_cycles", stalls, 31);
        check("div_done_pulses", dones, 1);
        cycle("div_after");

        // Multiply
        set_in(0, 0, 0, 0, 0, 0, 0, 1, 0, 0); cycle("mul_start");
        set_in(0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        stalls = 0;
        for (int i = 0; i < 4; i++) begin
            cycle("mul_wait");
            if (!last_obs[5]) stalls++;
        end
        check("mul_stall_cycles", stalls, 3);
        cycle("mul_after");

        // MDU op in ID while EX starts the MDU, then restart while busy
        set_in(0, 0, 0, 1, 0, 0, 0, 1, 1, 0); cycle("start_and_use");
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) cycle("div_run");
        set_in(0, 0, 0, 0, 0, 0, 0, 1, 0, 0); cycle("restart_mul");
        set_in(0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) cycle("restart_wait");
        check_counts("mdu");

        // Reset in the middle of a divide
        set_in(0, 0, 0, 0, 0, 0, 0, 1, 1, 0); cycle("div2_start");
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 9; i++) cycle("div2_run");
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_busy", {31'd0, mdu_busy}, 32'd0);
        check("rst_mid_done", {31'd0, mdu_done}, 32'd0);
        m_rem = 0; m_stall_cnt = 0; m_flush_cnt = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        set_in(0, 0, 0, 1, 0, 0, 0, 0, 0, 0); cycle("mflo_after_rst");

        // Saturation of the stall counter
        set_in(8, 0, 0, 0, 0, 1, 8, 0, 0, 0);
        repeat (70000) @(posedge clk);
        #1;
`ifdef HAZARD_STATS_EN
        check("sat_stallcnt", {16'd0, stall_count}, 32'h0000FFFF);
        repeat (5) @(posedge clk);
        #1;
        check("sat_hold", {16'd0, stall_count}, 32'h0000FFFF);
`else
        check("sat_stallcnt", {16'd0, stall_count}, 32'd0);
        repeat (5) @(posedge clk);
        #1;
        check("sat_hold", {16'd0, stall_count}, 32'd0);
`endif
        check("sat_flushcnt", {16'd0, flush_count}, 32'd0);

        if (sb.size() != 0) check("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
